pulse_meter: RTL and testbench

//  Receive-side counterpart of the pulse generator: measures an incoming pulse train.

---
 rtl/pulse_meter.sv | 159 +++++++++++++++
 tb/tb_pulse_meter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_meter
// Brief    : Synchronises an asynchronous pulse train and reports the high
//            width and rise-to-rise period of each complete period in clks.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_s_d;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_hw_lat;

    logic w_s;
    logic w_sync_ok;
    logic w_rise;
    logic w_fall;
    logic w_open;
    logic w_close;
    logic w_latch_hw;
    logic w_sat;
    logic w_counting;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_sync_ok = r_fill[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign busy      = (r_state == ST_HIGH) || (r_state == ST_LOW);

    // r_fill marks when the last sync stage holds a real sample rather than
    // its reset value, so a pulse already high at reset is not mistaken for low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_fill <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_open      = 1'b0;
        w_close     = 1'b0;
        w_latch_hw  = 1'b0;
        w_sat       = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sync_ok && !w_s) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HIGH;
                        w_open      = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = ST_LOW;
                        w_latch_hw  = 1'b1;
                    end else if (r_pcnt == c_cnt_max) begin
                        w_state_nxt = ST_IDLE;
                        w_sat       = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HIGH;
                        w_open      = 1'b1;
                        w_close     = 1'b1;
                    end else if (r_pcnt == c_cnt_max) begin
                        w_state_nxt = ST_IDLE;
                        w_sat       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_counting = enable && busy;

    // The closing rise registers the report, so meas_valid lands one clk later
    // carrying the pcnt value seen at the rise (which equals the period).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt     <= '0;
            r_hw_lat   <= '0;
            high_width <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= w_close;
            if (w_open) begin
                r_pcnt <= c_cnt_one;
            end else if (w_counting && !w_sat) begin
                r_pcnt <= r_pcnt + c_cnt_one;
            end
            if (w_latch_hw) begin
                r_hw_lat <= r_pcnt;
            end
            if (w_close) begin
                high_width <= r_hw_lat;
                period     <= r_pcnt;
                overflow   <= 1'b0;
            end else if (w_sat) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_meter
// Brief    : Self-checking bench for pulse_meter (CNT_W=16 and CNT_W=8 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic pulse_in;

    logic [15:0] hw16, p16;
    logic        mv16, ovf16, busy16;
    logic [7:0]  hw8, p8;
    logic        mv8, ovf8, busy8;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int strobes16 = 0;
    int strobes8  = 0;
    int prev16    = -1;
    int prev8     = -1;
    int exp_hw    = 0;
    int exp_p     = 0;
    bit chk_space = 1'b1;

    typedef struct {
        int h;
        int l;
        int n;
        int exp_hw;
        int exp_p;
    } vec_t;

    vec_t vecs[7];

    pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pulse_in   (pulse_in),
        .high_width (hw16),
        .period     (p16),
        .meas_valid (mv16),
        .overflow   (ovf16),
        .busy       (busy16)
    );

    pulse_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pulse_in   (pulse_in),
        .high_width (hw8),
        .period     (p8),
        .meas_valid (mv8),
        .overflow   (ovf8),
        .busy       (busy8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Every strobe must carry the expected report and arrive one period apart.
    always @(negedge clk) begin
        cyc++;
        if (mv16 === 1'b1) begin
            strobes16++;
            check("hw16", 32'(hw16), exp_hw);
            check("period16", 32'(p16), exp_p);
            if (chk_space && prev16 >= 0) check("spacing16", cyc - prev16, exp_p);
            prev16 = cyc;
        end
        if (mv8 === 1'b1) begin
            strobes8++;
            check("hw8", 32'(hw8), exp_hw);
            check("period8", 32'(p8), exp_p);
            if (chk_space && prev8 >= 0) check("spacing8", cyc - prev8, exp_p);
            prev8 = cyc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(1);
    endtask

    // Abort any measurement in progress and re-arm with fresh bookkeeping.
    task automatic start_vec(input int ehw, input int ep);
        enable = 1'b0;
        cycles(1);
        enable = 1'b1;
        cycles(2);
        strobes16 = 0;
        strobes8  = 0;
        prev16    = -1;
        prev8     = -1;
        exp_hw    = ehw;
        exp_p     = ep;
    endtask

    task automatic period_of(input int h, input int l);
        pulse_in = 1'b1;
        cycles(h);
        pulse_in = 1'b0;
        cycles(l);
    endtask

    // n+1 rises give n complete periods.
    task automatic run_train(input int h, input int l, input int n, input int ehw, input int ep);
        start_vec(ehw, ep);
        for (int k = 0; k <= n; k++) period_of(h, l);
        cycles(6);
        check("strobes16", strobes16, n);
        check("strobes8", strobes8, n);
        check("ovf16", 32'(ovf16), 0);
        check("ovf8", 32'(ovf8), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{h: 4, l: 6, n: 4, exp_hw: 4, exp_p: 10};
        vecs[1] = '{h: 1, l: 1, n: 6, exp_hw: 1, exp_p: 2};
        vecs[2] = '{h: 3, l: 5, n: 3, exp_hw: 3, exp_p: 8};
        vecs[3] = '{h: 5, l: 7, n: 3, exp_hw: 5, exp_p: 12};
        vecs[4] = '{h: 2, l: 1, n: 3, exp_hw: 2, exp_p: 3};
        vecs[5] = '{h: 1, l: 2, n: 3, exp_hw: 1, exp_p: 3};
        vecs[6] = '{h: 7, l: 3, n: 2, exp_hw: 7, exp_p: 10};

        reset    = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;
        cycles(3);
        check("reset_out16", {hw16, p16, mv16, ovf16, busy16}, 0);
        check("reset_out8", {hw8, p8, mv8, ovf8, busy8}, 0);
        reset  = 1'b0;
        enable = 1'b1;
        cycles(2);

        for (int i = 0; i < 7; i++) begin
            run_train(vecs[i].h, vecs[i].l, vecs[i].n, vecs[i].exp_hw, vecs[i].exp_p);
        end

        // Pulse already high at reset release is discarded.
        pulse_in = 1'b1;
        do_reset();
        start_vec(3, 8);
        cycles(8);
        check("prehigh_busy16", 32'(busy16), 0);
        check("prehigh_busy8", 32'(busy8), 0);
        check("prehigh_strobes", strobes16 + strobes8, 0);
        pulse_in = 1'b0;
        cycles(5);
        check("prehigh_low_busy16", 32'(busy16), 0);
        run_train(3, 5, 2, 3, 8);

        // Saturation on the 8-bit counter.
        pulse_in = 1'b0;
        do_reset();
        start_vec(5, 12);
        cycles(4);
        pulse_in = 1'b1;
        cycles(200);
        check("ovf8_before_sat", 32'(ovf8), 0);
        cycles(100);
        check("ovf8_sat", 32'(ovf8), 1);
        check("busy8_sat", 32'(busy8), 0);
        check("busy16_long_high", 32'(busy16), 1);
        check("sat_strobes", strobes16 + strobes8, 0);
        pulse_in = 1'b0;
        cycles(3);
        check("ovf8_sticky", 32'(ovf8), 1);
        run_train(5, 7, 2, 5, 12);

        // Asynchronous reset in the LOW phase clears outputs without a clock.
        run_train(4, 6, 1, 4, 10);
        check("prelow_busy16", 32'(busy16), 1);
        check("prelow_hw16", 32'(hw16), 4);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst16", {hw16, p16, mv16, ovf16, busy16}, 0);
        check("async_rst8", {hw8, p8, mv8, ovf8, busy8}, 0);
        #3;
        reset = 1'b0;
        cycles(2);
        run_train(3, 4, 2, 3, 7);

        // One-clk enable drop while HIGH: the aborted period is never reported.
        start_vec(6, 10);
        chk_space = 1'b0;
        period_of(6, 4);
        pulse_in = 1'b1;
        cycles(5);
        enable = 1'b0;
        cycles(1);
        enable   = 1'b1;
        pulse_in = 1'b0;
        cycles(4);
        check("abort_strobes", strobes16, 1);
        check("abort_hold_hw16", 32'(hw16), 6);
        check("abort_hold_p16", 32'(p16), 10);
        check("abort_busy16", 32'(busy16), 0);
        period_of(6, 4);
        period_of(6, 4);
        period_of(6, 4);
        cycles(6);
        check("abort_total16", strobes16, 3);
        check("abort_total8", strobes8, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
